// File: rtl/wb_uart_multi_pkg.sv
// Shared definitions for the multi-channel Wishbone UART: register map,
// STATUS bit positions, engine state encodings and divisor clamping.
package wb_uart_multi_pkg;
   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_DIV    = 2'd2;
   localparam logic [1:0] REG_IER    = 2'd3;

   localparam int ST_TX_FULL  = 0;
   localparam int ST_TX_EMPTY = 1;
   localparam int ST_RX_EMPTY = 2;
   localparam int ST_RX_FULL  = 3;
   localparam int ST_RXOVR    = 4;
   localparam int ST_FERR     = 5;
   localparam int ST_TXOVF    = 6;
   localparam int ST_TX_BUSY  = 7;

   localparam logic [15:0] MIN_DIV = 16'd4;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   function automatic logic [15:0] eff_div(input logic [15:0] d);
      return (d < MIN_DIV) ? MIN_DIV : d;
   endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO only
// lands when a pop happens in the same cycle, a pop from empty is ignored.
module uart_sync_fifo
   import wb_uart_multi_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == DEPTH_C);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/wb_uart_multi.sv
// N-channel 8N1 UART behind a Wishbone slave: per-channel TX/RX FIFOs,
// runtime divisor, sticky error flags and maskable level interrupts.
module wb_uart_multi
   import wb_uart_multi_pkg::*;
#(
   parameter int          NUM_CH       = 2,
   parameter int          FIFO_DEPTH   = 16,
   parameter int          ADDRWIDTH    = 10,
   parameter logic [15:0] DIV_RESET    = 16'd104,
   parameter logic [31:0] DEFAULT_READ = 32'hBAD_FAB_AC
) (
   input  logic                 WB_CLK,
   input  logic                 WB_RSTn,
   input  logic [ADDRWIDTH-1:0] WBs_ADR,
   input  logic                 WBs_CYC,
   input  logic                 WBs_STB,
   input  logic                 WBs_WE,
   input  logic [3:0]           WBs_BYTE_STB,
   input  logic [31:0]          WBs_WR_DAT,
   output logic [31:0]          WBs_RD_DAT,
   output logic                 WBs_ACK,
   input  logic [NUM_CH-1:0]    UART_SIN_i,
   output logic [NUM_CH-1:0]    UART_SOUT_o,
   output logic [NUM_CH-1:0]    UART_Intr_o,
   output logic                 UART_Intr_any_o
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic        ack, acc, wr_acc, rd_acc, in_window;
   logic [1:0]  sel_ch, reg_sel;
   logic [31:0] rd_dat, rd_next;
   logic        unused;

   logic [7:0]        status_v [NUM_CH];
   logic [15:0]       div_v    [NUM_CH];
   logic [2:0]        ier_v    [NUM_CH];
   logic [7:0]        rx_byte_v[NUM_CH];
   logic [NUM_CH-1:0] rx_empty_v;

   // Every access is performed on the edge that raises ACK, so side effects happen once.
   assign acc       = WBs_CYC & WBs_STB & ~ack;
   assign wr_acc    = acc & WBs_WE;
   assign rd_acc    = acc & ~WBs_WE;
   assign in_window = (WBs_ADR[ADDRWIDTH-1:6] == '0);
   assign sel_ch    = WBs_ADR[5:4];
   assign reg_sel   = WBs_ADR[3:2];
   assign unused    = ^{WBs_ADR[1:0], WBs_WR_DAT[31:16], WBs_BYTE_STB[3:2]};

   always_comb begin
      rd_next = DEFAULT_READ;
      if (in_window) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (sel_ch == c[1:0]) begin
               case (reg_sel)
                  REG_DATA:   rd_next = rx_empty_v[c] ? 32'h0 : {24'h0, rx_byte_v[c]};
                  REG_STATUS: rd_next = {24'h0, status_v[c]};
                  REG_DIV:    rd_next = {16'h0, div_v[c]};
                  default:    rd_next = {29'h0, ier_v[c]};
               endcase
            end
         end
      end
   end

   always_ff @(posedge WB_CLK or negedge WB_RSTn) begin
      if (!WB_RSTn) begin
         ack    <= 1'b0;
         rd_dat <= '0;
      end else begin
         ack <= acc;
         if (acc) rd_dat <= rd_next;
      end
   end

   assign WBs_ACK         = ack;
   assign WBs_RD_DAT      = rd_dat;
   assign UART_Intr_any_o = |UART_Intr_o;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic          sel, wr_data, wr_status, wr_div, wr_ier, rd_data;
      logic [15:0]   div_q, tx_div_q, rx_div_q, tx_cnt, rx_cnt, rx_tgt;
      logic [2:0]    ier_q, tx_idx, rx_idx;
      logic          rxovr_q, ferr_q, txovf_q, intr_q;
      logic          tx_pop, tx_full, tx_empty, tx_bit_done;
      logic          rx_push, rx_pop, rx_full, rx_empty, rx_tick;
      logic [7:0]    tx_dout, tx_shift, rx_dout, rx_shift, status;
      logic [CW-1:0] tx_count, rx_count;
      logic          sin_s1, sin_s2, sin_d;
      tx_state_t     tx_state, tx_next;
      rx_state_t     rx_state, rx_next;

      assign sel       = in_window & (sel_ch == 2'(c));
      assign wr_data   = wr_acc & sel & (reg_sel == REG_DATA) & WBs_BYTE_STB[0];
      assign wr_status = wr_acc & sel & (reg_sel == REG_STATUS);
      assign wr_div    = wr_acc & sel & (reg_sel == REG_DIV);
      assign wr_ier    = wr_acc & sel & (reg_sel == REG_IER);
      assign rd_data   = rd_acc & sel & (reg_sel == REG_DATA);
      assign rx_pop    = rd_data;

      uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
         .clk(WB_CLK), .rst_n(WB_RSTn), .push(wr_data), .pop(tx_pop),
         .din(WBs_WR_DAT[7:0]), .dout(tx_dout), .full(tx_full), .empty(tx_empty),
         .count(tx_count));

      uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
         .clk(WB_CLK), .rst_n(WB_RSTn), .push(rx_push), .pop(rx_pop),
         .din(rx_shift), .dout(rx_dout), .full(rx_full), .empty(rx_empty),
         .count(rx_count));

      // Sticky flags: a new event in the same cycle as a W1C wins over the clear.
      always_ff @(posedge WB_CLK or negedge WB_RSTn) begin
         if (!WB_RSTn) begin
            div_q   <= DIV_RESET;
            ier_q   <= '0;
            rxovr_q <= 1'b0;
            ferr_q  <= 1'b0;
            txovf_q <= 1'b0;
            intr_q  <= 1'b0;
         end else begin
            if (wr_div & WBs_BYTE_STB[0]) div_q[7:0]  <= WBs_WR_DAT[7:0];
            if (wr_div & WBs_BYTE_STB[1]) div_q[15:8] <= WBs_WR_DAT[15:8];
            if (wr_ier) ier_q <= WBs_WR_DAT[2:0];
            rxovr_q <= (rxovr_q & ~(wr_status & WBs_WR_DAT[ST_RXOVR])) | (rx_push & rx_full & ~rx_pop);
            ferr_q  <= (ferr_q  & ~(wr_status & WBs_WR_DAT[ST_FERR]))  | (rx_push & ~sin_s2);
            txovf_q <= (txovf_q & ~(wr_status & WBs_WR_DAT[ST_TXOVF])) | (wr_data & tx_full & ~tx_pop);
            intr_q  <= |(ier_q & {rxovr_q | ferr_q | txovf_q,
                                  (tx_count == '0) && (tx_state == TX_IDLE),
                                  rx_count != '0});
         end
      end

      always_comb begin
         status              = 8'h00;
         status[ST_TX_FULL]  = tx_full;
         status[ST_TX_EMPTY] = tx_empty;
         status[ST_RX_EMPTY] = rx_empty;
         status[ST_RX_FULL]  = rx_full;
         status[ST_RXOVR]    = rxovr_q;
         status[ST_FERR]     = ferr_q;
         status[ST_TXOVF]    = txovf_q;
         status[ST_TX_BUSY]  = (tx_state != TX_IDLE);
      end

      assign status_v[c]   = status;
      assign div_v[c]      = div_q;
      assign ier_v[c]      = ier_q;
      assign rx_byte_v[c]  = rx_dout;
      assign rx_empty_v[c] = rx_empty;
      assign UART_Intr_o[c] = intr_q;
      assign UART_SOUT_o[c] = (tx_state == TX_START) ? 1'b0 :
                              (tx_state == TX_DATA)  ? tx_shift[0] : 1'b1;

      always_comb begin
         tx_next     = tx_state;
         tx_pop      = 1'b0;
         tx_bit_done = (tx_cnt == tx_div_q - 16'd1);
         case (tx_state)
            TX_IDLE:  if (!tx_empty) begin tx_next = TX_START; tx_pop = 1'b1; end
            TX_START: if (tx_bit_done) tx_next = TX_DATA;
            TX_DATA:  if (tx_bit_done && tx_idx == 3'd7) tx_next = TX_STOP;
            TX_STOP:  if (tx_bit_done) begin
                         if (!tx_empty) begin tx_next = TX_START; tx_pop = 1'b1; end
                         else tx_next = TX_IDLE;
                      end
            default:  tx_next = TX_IDLE;
         endcase
      end

      // Divisor is captured when a byte leaves the FIFO, so it only changes between frames.
      always_ff @(posedge WB_CLK or negedge WB_RSTn) begin
         if (!WB_RSTn) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_div_q <= MIN_DIV;
         end else begin
            tx_state <= tx_next;
            if (tx_pop) begin
               tx_cnt   <= '0;
               tx_idx   <= '0;
               tx_div_q <= eff_div(div_q);
            end else if (tx_state != TX_IDLE) begin
               if (tx_bit_done) begin
                  tx_cnt <= '0;
                  if (tx_state == TX_DATA) tx_idx <= tx_idx + 3'd1;
               end else begin
                  tx_cnt <= tx_cnt + 16'd1;
               end
            end
         end
      end

      always_ff @(posedge WB_CLK) begin
         if (tx_pop) tx_shift <= tx_dout;
         else if (tx_state == TX_DATA && tx_bit_done) tx_shift <= {1'b0, tx_shift[7:1]};
      end

      always_ff @(posedge WB_CLK or negedge WB_RSTn) begin
         if (!WB_RSTn) begin
            sin_s1 <= 1'b1;
            sin_s2 <= 1'b1;
            sin_d  <= 1'b1;
         end else begin
            sin_s1 <= UART_SIN_i[c];
            sin_s2 <= sin_s1;
            sin_d  <= sin_s2;
         end
      end

      // Start bit is rechecked half a bit after the edge; later samples land mid-bit.
      assign rx_tgt  = (rx_state == RX_START) ? ({1'b0, rx_div_q[15:1]} - 16'd1) : (rx_div_q - 16'd1);
      assign rx_tick = (rx_cnt == rx_tgt);

      always_comb begin
         rx_next = rx_state;
         rx_push = 1'b0;
         case (rx_state)
            RX_IDLE:  if (sin_d && !sin_s2) rx_next = RX_START;
            RX_START: if (rx_tick) rx_next = sin_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_idx == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (rx_tick) begin rx_next = RX_IDLE; rx_push = 1'b1; end
            default:  rx_next = RX_IDLE;
         endcase
      end

      always_ff @(posedge WB_CLK or negedge WB_RSTn) begin
         if (!WB_RSTn) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_div_q <= MIN_DIV;
         end else begin
            rx_state <= rx_next;
            if (rx_state == RX_IDLE) begin
               rx_cnt   <= '0;
               rx_idx   <= '0;
               rx_div_q <= eff_div(div_q);
            end else if (rx_tick) begin
               rx_cnt <= '0;
               if (rx_state == RX_DATA) rx_idx <= rx_idx + 3'd1;
            end else begin
               rx_cnt <= rx_cnt + 16'd1;
            end
         end
      end

      always_ff @(posedge WB_CLK) begin
         if (rx_state == RX_DATA && rx_tick) rx_shift <= {sin_s2, rx_shift[7:1]};
      end
   end
endmodule

// File: tb/tb_wb_uart_multi.sv
// Scoreboard bench for wb_uart_multi: bus accesses, TX bit timing, loopback,
// RX overflow, framing error, glitch rejection, unmapped reads and reset.
module tb_wb_uart_multi;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  adr;
   logic        cyc, stb, we;
   logic [3:0]  be;
   logic [31:0] wdat, rdat;
   logic        ack;
   logic [1:0]  sin, sout, intr, sin_drv;
   logic        intr_any, loop;
   logic [7:0]  exp_q[$];
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;
   assign sin = loop ? sout : sin_drv;

   wb_uart_multi dut (
      .WB_CLK(clk), .WB_RSTn(rst_n), .WBs_ADR(adr), .WBs_CYC(cyc), .WBs_STB(stb),
      .WBs_WE(we), .WBs_BYTE_STB(be), .WBs_WR_DAT(wdat), .WBs_RD_DAT(rdat),
      .WBs_ACK(ack), .UART_SIN_i(sin), .UART_SOUT_o(sout), .UART_Intr_o(intr),
      .UART_Intr_any_o(intr_any));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wb_xfer(input logic [9:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] b, output logic [31:0] q);
      int n;
      tick(1);
      adr = a; we = w; wdat = d; be = b; cyc = 1'b1; stb = 1'b1;
      n = 0;
      do begin tick(1); n++; end while (!ack && n < 20);
      if (!ack) chk("ack_timeout", 32'(ack), 32'd1);
      q = rdat;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic wb_wr(input logic [9:0] a, input logic [31:0] d);
      logic [31:0] q;
      wb_xfer(a, 1'b1, d, 4'hF, q);
   endtask

   task automatic wb_rd(input logic [9:0] a, output logic [31:0] q);
      wb_xfer(a, 1'b0, 32'h0, 4'hF, q);
   endtask

   task automatic send_frame(input int ch, input logic [7:0] b, input logic stop_bit);
      logic [9:0] f;
      f = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         sin_drv[ch] = f[i];
         tick(4);
      end
      sin_drv[ch] = 1'b1;
      tick(4);
   endtask

   task automatic wait_low(input int ch, input string tag);
      int n;
      n = 0;
      while (sout[ch] && n < 50) begin tick(1); n++; end
      if (sout[ch]) chk(tag, 32'(sout[ch]), 32'd0);
   endtask

   initial begin
      #400us;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d, st;
      logic [7:0]  b;
      logic [9:0]  tx_exp;
      int          n;
      rst_n = 1'b0; adr = '0; cyc = 1'b0; stb = 1'b0; we = 1'b0; be = 4'h0; wdat = '0;
      sin_drv = 2'b11; loop = 1'b0;

      // reset state
      tick(3);
      chk("rst_sout", 32'(sout), 32'h3);
      chk("rst_ack", 32'(ack), 32'h0);
      chk("rst_rddat", rdat, 32'h0);
      chk("rst_intr", 32'(intr), 32'h0);
      rst_n = 1'b1;
      tick(2);
      wb_rd(10'h004, d); chk("rst_status0", d, 32'h06);
      wb_rd(10'h008, d); chk("rst_div0", d, 32'd104);
      wb_rd(10'h00C, d); chk("rst_ier0", d, 32'h0);

      // ch1 TX of 0xA5 at 8 clocks per bit, TX-empty interrupt
      wb_wr(10'h018, 32'd8);
      wb_wr(10'h01C, 32'h2);
      tick(2);
      chk("intr_idle", 32'(intr[1]), 32'd1);
      chk("intr_any_idle", 32'(intr_any), 32'd1);
      wb_wr(10'h010, 32'hA5);
      wait_low(1, "tx_start_timeout");
      chk("intr_busy", 32'(intr[1]), 32'd0);
      tx_exp = {1'b1, 8'hA5, 1'b0};
      tick(4);
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("tx_bit%0d", i), 32'(sout[1]), 32'(tx_exp[i]));
         if (i < 9) tick(8);
      end
      tick(8);
      chk("intr_after_stop", 32'(intr[1]), 32'd1);
      chk("sout0_idle", 32'(sout[0]), 32'd1);

      // loopback ch0 at minimum divisor; 18th write lands while FIFO is full
      loop = 1'b1;
      wb_wr(10'h008, 32'd4);
      for (int i = 0; i < 18; i++) begin
         b = 8'($urandom);
         if (i < 17) exp_q.push_back(b);
         wb_wr(10'h000, {24'h0, b});
      end
      wb_rd(10'h004, st);
      chk("txovf_set", 32'(st[6]), 32'd1);
      for (int i = 0; i < 17; i++) begin
         n = 0;
         do begin wb_rd(10'h004, st); n++; end while (st[2] && n < 100);
         wb_rd(10'h000, d);
         chk($sformatf("lb_byte%0d", i), d, {24'h0, exp_q.pop_front()});
      end
      wb_wr(10'h004, 32'h40);
      tick(20);
      wb_rd(10'h004, st);
      chk("status_after_w1c", st, 32'h06);
      loop = 1'b0;

      // RX overflow on ch1
      wb_wr(10'h018, 32'd4);
      for (int i = 0; i < 17; i++) begin
         b = 8'($urandom);
         if (i < 16) exp_q.push_back(b);
         send_frame(1, b, 1'b1);
      end
      tick(10);
      wb_rd(10'h014, st);
      chk("rx_full_ovr", st, 32'h1A);
      for (int i = 0; i < 16; i++) begin
         wb_rd(10'h010, d);
         chk($sformatf("rx_byte%0d", i), d, {24'h0, exp_q.pop_front()});
      end
      wb_rd(10'h010, d);
      chk("rx_empty_read", d, 32'h0);
      wb_rd(10'h014, st);
      chk("rx_drained", st, 32'h16);

      // framing error with error interrupt
      wb_wr(10'h014, 32'h70);
      wb_wr(10'h01C, 32'h4);
      tick(2);
      chk("intr_err_clear", 32'(intr[1]), 32'd0);
      send_frame(1, 8'h3C, 1'b0);
      tick(10);
      wb_rd(10'h014, st);
      chk("ferr_status", st, 32'h22);
      chk("intr_ferr", 32'(intr[1]), 32'd1);
      chk("intr_any_ferr", 32'(intr_any), 32'd1);
      wb_rd(10'h010, d);
      chk("ferr_byte", d, 32'h3C);

      // one-clock glitch is rejected
      wb_wr(10'h014, 32'h20);
      sin_drv[1] = 1'b0;
      tick(1);
      sin_drv[1] = 1'b1;
      tick(30);
      wb_rd(10'h014, st);
      chk("glitch_status", st, 32'h06);
      chk("glitch_intr", 32'(intr[1]), 32'd0);
      wb_rd(10'h010, d);
      chk("glitch_data", d, 32'h0);

      // unmapped reads and single-cycle ACK
      wb_rd(10'h030, d);
      chk("unmapped_ch2", d, 32'hBADFABAC);
      chk("ack_high", 32'(ack), 32'd1);
      tick(1);
      chk("ack_one_cycle", 32'(ack), 32'd0);
      wb_wr(10'h048, 32'd9);
      wb_rd(10'h048, d);
      chk("unmapped_hi", d, 32'hBADFABAC);
      wb_rd(10'h008, d);
      chk("div0_kept", d, 32'd4);

      // reset in the middle of a frame
      wb_wr(10'h000, 32'h00);
      wait_low(0, "tx0_start_timeout");
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_sout", 32'(sout), 32'h3);
      chk("midrst_ack", 32'(ack), 32'd0);
      chk("midrst_intr", 32'(intr), 32'd0);
      tick(2);
      rst_n = 1'b1;
      tick(2);
      wb_rd(10'h004, st); chk("postrst_status", st, 32'h06);
      wb_rd(10'h008, d);  chk("postrst_div", d, 32'd104);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
